// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Four-phase (IDLE/READ/EXEC/WB) instruction sequencer around
//                an external combinational ALU. Owns a 16 x 32 register file
//                and the architectural flags register. One instruction is in
//                flight at a time.
//                Optional build macro ALU_SEQUENCER_EXEC_WAIT_EN inserts an
//                extra EXEC2 state so the ALU gets two cycles to settle.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Instr,
    input  logic        Instr_Valid,
    output logic        Instr_Ready,
    output logic [31:0] Alu_In1,
    output logic [31:0] Alu_In2,
    output logic [3:0]  Alu_Opcode,
    output logic [3:0]  Alu_Cond,
    output logic        Alu_S,
    output logic [2:0]  Alu_SR_Cont,
    output logic [4:0]  Alu_SR_Bit,
    output logic [15:0] Alu_Imm,
    input  logic [31:0] Alu_Out,
    input  logic [3:0]  Alu_Flags,
    input  logic        Alu_Cond_Met,
    output logic        Done,
    output logic        Done_Wr,
    output logic [3:0]  Done_Rd,
    output logic [31:0] Done_Data,
    output logic [3:0]  Flags_Q,
    input  logic [3:0]  Dbg_Addr,
    output logic [31:0] Dbg_Data
);

    localparam logic [3:0] c_OP_NOP = 4'b1111;
    localparam logic [3:0] c_OP_CMP = 4'b1011;
    localparam logic [3:0] c_OP_WR2 = 4'b1101;

`ifdef ALU_SEQUENCER_EXEC_WAIT_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_EXEC2 = 3'd3,
        S_WB    = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;
`endif

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_instr;
    logic [31:0] r_regs [16];
    logic [3:0]  r_flags;

    logic [31:0] r_alu_in1;
    logic [31:0] r_alu_in2;
    logic [3:0]  r_alu_opcode;
    logic [3:0]  r_alu_cond;
    logic        r_alu_s;
    logic [2:0]  r_alu_sr_cont;
    logic [4:0]  r_alu_sr_bit;
    logic [15:0] r_alu_imm;

    logic [31:0] r_res_out;
    logic [3:0]  r_res_flags;
    logic        r_res_met;

    logic        w_accept;
    logic        w_sample;
    logic        w_wr_reg;
    logic        w_wr_flags;
    logic        w_ready;
    logic        w_done;

    // Fields of the latched instruction
    logic [3:0]  w_op;
    logic [3:0]  w_cond;
    logic        w_s;
    logic [2:0]  w_sr_cont;
    logic [3:0]  w_rd;
    logic [15:0] w_imm;
    logic [3:0]  w_rn;
    logic [3:0]  w_rm;

    assign w_op      = r_instr[31:28];
    assign w_cond    = r_instr[27:24];
    assign w_s       = r_instr[23];
    assign w_sr_cont = r_instr[22:20];
    assign w_rd      = r_instr[19:16];
    assign w_imm     = r_instr[15:0];
    assign w_rn      = r_instr[15:12];
    assign w_rm      = r_instr[11:8];

    assign w_accept = (r_state == S_IDLE) && Instr_Valid;

`ifdef ALU_SEQUENCER_EXEC_WAIT_EN
    assign w_sample = (r_state == S_EXEC2);
`else
    assign w_sample = (r_state == S_EXEC);
`endif

    // Register write happens only for data-producing opcodes whose condition held;
    // NOP (1111) falls outside both ranges so it never writes.
    assign w_wr_reg   = r_res_met && ((w_op <= 4'd7) || (w_op == c_OP_WR2));
    assign w_wr_flags = r_res_met && (((w_op <= 4'd5) && w_s) || (w_op == c_OP_CMP));

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake/completion decode
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (Instr_Valid) begin
                    w_next_state = S_READ;
                end
            end
            S_READ: w_next_state = S_EXEC;
`ifdef ALU_SEQUENCER_EXEC_WAIT_EN
            S_EXEC:  w_next_state = S_EXEC2;
            S_EXEC2: w_next_state = S_WB;
`else
            S_EXEC:  w_next_state = S_WB;
`endif
            S_WB: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Capture the instruction word on accept; ignored at all other times
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_instr <= '0;
        end else if (w_accept) begin
            r_instr <= Instr;
        end
    end

    // Operand fetch and control-field launch towards the ALU during READ
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_alu_in1     <= '0;
            r_alu_in2     <= '0;
            r_alu_opcode  <= '0;
            r_alu_cond    <= '0;
            r_alu_s       <= 1'b0;
            r_alu_sr_cont <= '0;
            r_alu_sr_bit  <= '0;
            r_alu_imm     <= '0;
        end else if (r_state == S_READ) begin
            r_alu_in1     <= r_regs[w_rn];
            r_alu_in2     <= r_regs[w_rm];
            r_alu_s       <= w_s;
            r_alu_sr_cont <= w_sr_cont;
            r_alu_sr_bit  <= w_imm[4:0];
            r_alu_imm     <= w_imm;
            // NOP is presented to the ALU as an unconditional opcode 0
            if (w_op == c_OP_NOP) begin
                r_alu_opcode <= 4'b0000;
                r_alu_cond   <= 4'b0000;
            end else begin
                r_alu_opcode <= w_op;
                r_alu_cond   <= w_cond;
            end
        end
    end

    // Sample the ALU's combinational results on the last execute cycle
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_res_out   <= '0;
            r_res_flags <= '0;
            r_res_met   <= 1'b0;
        end else if (w_sample) begin
            r_res_out   <= Alu_Out;
            r_res_flags <= Alu_Flags;
            r_res_met   <= Alu_Cond_Met;
        end
    end

    // Register file writeback at the end of WB
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else if ((r_state == S_WB) && w_wr_reg) begin
            r_regs[w_rd] <= r_res_out;
        end
    end

    // Architectural flags update at the end of WB; held otherwise
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_flags <= '0;
        end else if ((r_state == S_WB) && w_wr_flags) begin
            r_flags <= r_res_flags;
        end
    end

    assign Instr_Ready = w_ready;

    assign Alu_In1     = r_alu_in1;
    assign Alu_In2     = r_alu_in2;
    assign Alu_Opcode  = r_alu_opcode;
    assign Alu_Cond    = r_alu_cond;
    assign Alu_S       = r_alu_s;
    assign Alu_SR_Cont = r_alu_sr_cont;
    assign Alu_SR_Bit  = r_alu_sr_bit;
    assign Alu_Imm     = r_alu_imm;

    assign Done      = w_done;
    assign Done_Wr   = w_done && w_wr_reg;
    assign Done_Rd   = w_rd;
    assign Done_Data = (w_done && w_wr_reg) ? r_res_out : 32'd0;
    assign Flags_Q   = r_flags;

    // Debug port reads the architectural register file, so a write in WB
    // becomes visible only after the WB->IDLE edge
    assign Dbg_Data = r_regs[Dbg_Addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Scoreboard bench for alu_sequencer with a behavioural ALU and
//                a reference model of the register file and flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

`ifdef ALU_SEQUENCER_EXEC_WAIT_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        Clk;
    logic        Rst;
    logic [31:0] Instr;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic [31:0] Alu_In1, Alu_In2;
    logic [3:0]  Alu_Opcode, Alu_Cond;
    logic        Alu_S;
    logic [2:0]  Alu_SR_Cont;
    logic [4:0]  Alu_SR_Bit;
    logic [15:0] Alu_Imm;
    logic [31:0] Alu_Out;
    logic [3:0]  Alu_Flags;
    logic        Alu_Cond_Met;
    logic        Done, Done_Wr;
    logic [3:0]  Done_Rd;
    logic [31:0] Done_Data;
    logic [3:0]  Flags_Q;
    logic [3:0]  Dbg_Addr;
    logic [31:0] Dbg_Data;

    alu_sequencer dut (
        .Clk(Clk), .Rst(Rst), .Instr(Instr), .Instr_Valid(Instr_Valid),
        .Instr_Ready(Instr_Ready), .Alu_In1(Alu_In1), .Alu_In2(Alu_In2),
        .Alu_Opcode(Alu_Opcode), .Alu_Cond(Alu_Cond), .Alu_S(Alu_S),
        .Alu_SR_Cont(Alu_SR_Cont), .Alu_SR_Bit(Alu_SR_Bit), .Alu_Imm(Alu_Imm),
        .Alu_Out(Alu_Out), .Alu_Flags(Alu_Flags), .Alu_Cond_Met(Alu_Cond_Met),
        .Done(Done), .Done_Wr(Done_Wr), .Done_Rd(Done_Rd), .Done_Data(Done_Data),
        .Flags_Q(Flags_Q), .Dbg_Addr(Dbg_Addr), .Dbg_Data(Dbg_Data)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Simple ALU: returns {cond_met, flags[3:0], out[31:0]}
    function automatic logic [36:0] alu_f(input logic [3:0] op, input logic [3:0] cond,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [15:0] imm, input logic [3:0] fl);
        logic [31:0] o;
        logic [3:0]  f;
        logic        m;
        case (op)
            4'd0:    o = a + b;
            4'd1:    o = a - b;
            4'd2:    o = a & b;
            4'd3:    o = a | b;
            4'd4:    o = a ^ b;
            4'd5:    o = b - a;
            4'd6:    o = {16'd0, imm};
            4'd7:    o = ~b;
            4'd13:   o = a + {16'd0, imm};
            default: o = a ^ b;
        endcase
        f = {o[31], (o == 32'd0), o[2], o[3]};
        case (cond)
            4'd0:    m = 1'b1;
            4'd1:    m = fl[2];
            4'd2:    m = ~fl[2];
            default: m = cond[0] ^ fl[3];
        endcase
        return {m, f, o};
    endfunction

    assign {Alu_Cond_Met, Alu_Flags, Alu_Out} =
        alu_f(Alu_Opcode, Alu_Cond, Alu_In1, Alu_In2, Alu_Imm, Flags_Q);

    typedef struct {
        logic        wr;
        logic [3:0]  rd;
        logic [31:0] data;
        logic [3:0]  flags;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_regs [16];
    logic [3:0]  m_flags;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] cond,
                                       input logic s, input logic [3:0] rd,
                                       input logic [3:0] rn, input logic [3:0] rm);
        return {op, cond, s, 3'b000, rd, rn, rm, 8'h00};
    endfunction

    function automatic logic [31:0] mk_imm(input logic [3:0] op, input logic [3:0] rd,
                                           input logic [15:0] imm);
        return {op, 4'd0, 1'b0, 3'b000, rd, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_flags = '0;
    endtask

    task automatic check_regs();
        for (int i = 0; i < 16; i++) begin
            Dbg_Addr = i[3:0];
            #1;
            chk($sformatf("reg_R%0d", i), Dbg_Data, m_regs[i]);
        end
        @(negedge Clk);
    endtask

    // Issue one instruction (caller is just after a negedge); checks handshake,
    // latency and debug-port timing, and posts the expected completion
    task automatic issue(input logic [31:0] ins);
        int          w;
        logic [3:0]  op, aop, acond, rd;
        logic [31:0] a, b, oldv, newv;
        logic [36:0] r;
        logic        met, wr, fw;
        exp_t        e;
        w = 0;
        while (!Instr_Ready && w < 20) begin
            @(negedge Clk);
            w++;
        end
        if (!Instr_Ready) chk("ready_timeout", {31'd0, Instr_Ready}, 32'd1);
        op    = ins[31:28];
        rd    = ins[19:16];
        aop   = (op == 4'hF) ? 4'h0 : op;
        acond = (op == 4'hF) ? 4'h0 : ins[27:24];
        a     = m_regs[ins[15:12]];
        b     = m_regs[ins[11:8]];
        r     = alu_f(aop, acond, a, b, ins[15:0], m_flags);
        met   = r[36];
        wr    = met && ((op <= 4'd7) || (op == 4'd13));
        fw    = met && (((op <= 4'd5) && ins[23]) || (op == 4'd11));
        oldv  = m_regs[rd];
        newv  = wr ? r[31:0] : oldv;
        e.wr    = wr;
        e.rd    = rd;
        e.data  = wr ? r[31:0] : 32'd0;
        e.flags = fw ? r[35:32] : m_flags;
        q.push_back(e);
        m_regs[rd] = newv;
        m_flags    = e.flags;

        Instr       = ins;
        Instr_Valid = 1'b1;
        @(posedge Clk);
        #1;
        Instr_Valid = 1'b0;
        Instr       = $urandom;
        Dbg_Addr    = rd;
        for (int k = 0; k <= LAT; k++) begin
            @(negedge Clk);
            chk($sformatf("ready_k%0d", k), {31'd0, Instr_Ready}, {31'd0, (k == LAT)});
            chk($sformatf("done_k%0d", k), {31'd0, Done}, {31'd0, (k == LAT - 1)});
            if (k == LAT - 1) begin
                chk("dbg_old_in_wb", Dbg_Data, oldv);
                chk("alu_opcode", {28'd0, Alu_Opcode}, {28'd0, aop});
                chk("alu_in1", Alu_In1, a);
                chk("alu_in2", Alu_In2, b);
            end
            if (k == LAT) chk("dbg_new_after_wb", Dbg_Data, newv);
        end
    endtask

    // Monitor: every Done is matched against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", {31'd0, Done}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("done_wr", {31'd0, Done_Wr}, {31'd0, e.wr});
                    chk("done_rd", {28'd0, Done_Rd}, {28'd0, e.rd});
                    chk("done_data", Done_Data, e.data);
                    @(negedge Clk);
                    chk("flags_q", {28'd0, Flags_Q}, {28'd0, e.flags});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        Rst         = 1'b1;
        Instr       = '0;
        Instr_Valid = 1'b0;
        Dbg_Addr    = '0;
        model_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_ready", {31'd0, Instr_Ready}, 32'd1);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_done_wr", {31'd0, Done_Wr}, 32'd0);
        chk("rst_done_rd", {28'd0, Done_Rd}, 32'd0);
        chk("rst_done_data", Done_Data, 32'd0);
        chk("rst_flags", {28'd0, Flags_Q}, 32'd0);
        chk("rst_alu_in1", Alu_In1, 32'd0);
        chk("rst_alu_opcode", {28'd0, Alu_Opcode}, 32'd0);
        chk("rst_alu_imm", {16'd0, Alu_Imm}, 32'd0);
        Rst = 1'b0;
        check_regs();

        // MOV immediate into R3
        issue(mk_imm(4'd6, 4'd3, 16'h1234));
        check_regs();
        // R1=5, R2=7, ADD S=1 R4 = R1 + R2
        issue(mk_imm(4'd6, 4'd1, 16'd5));
        issue(mk_imm(4'd6, 4'd2, 16'd7));
        issue(mk(4'd0, 4'd0, 1'b1, 4'd4, 4'd1, 4'd2));
        // Conditional (EQ) ADD that must not execute
        issue(mk(4'd0, 4'd1, 1'b1, 4'd4, 4'd1, 4'd2));
        // CMP of equal operands
        issue(mk_imm(4'd6, 4'd1, 16'd7));
        issue(mk(4'd11, 4'd0, 1'b0, 4'd9, 4'd1, 4'd2));
        // NOP and a same-register read/write
        issue(mk(4'd15, 4'd0, 1'b1, 4'd2, 4'd1, 4'd2));
        issue(mk(4'd0, 4'd0, 1'b0, 4'd1, 4'd1, 4'd1));
        check_regs();

        for (int n = 0; n < 60; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[27:24] = 4'($urandom_range(0, 4));
            issue(ins);
            if (n % 20 == 19) check_regs();
        end

        // Reset during EXEC of ADD R5: aborted, no Done, registers cleared
        issue(mk_imm(4'd6, 4'd1, 16'd5));
        Instr       = mk(4'd0, 4'd0, 1'b0, 4'd5, 4'd1, 4'd1);
        Instr_Valid = 1'b1;
        @(posedge Clk);
        #1;
        Instr_Valid = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("abort_in_exec_done", {31'd0, Done}, 32'd0);
        Rst = 1'b1;
        @(negedge Clk);
        chk("abort_no_done", {31'd0, Done}, 32'd0);
        Rst = 1'b0;
        model_reset();
        #1;
        chk("abort_ready_after_rst", {31'd0, Instr_Ready}, 32'd1);
        @(negedge Clk);
        chk("abort_ready_next", {31'd0, Instr_Ready}, 32'd1);
        chk("abort_no_done_after", {31'd0, Done}, 32'd0);
        chk("abort_flags", {28'd0, Flags_Q}, 32'd0);
        check_regs();

        for (int n = 0; n < 10; n++) begin
            issue($urandom);
        end
        check_regs();
        repeat (3) @(negedge Clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: none; register file fixed at 16 x 32 bits.
REQ-002 Clk  input  1  rising-edge clock, single clock domain.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 Instr  input  32  instruction word:
- [31:28] Opcode; [27:24] Cond; [23] S; [22:20] SR_Cont; [19:16] Rd; [15:0] Imm.
- Register fields: Imm[15:12] Rn, Imm[11:8] Rm, Imm[4:0] SR_Bit.
REQ-005 Instr_Valid  input  1  instruction offered.
REQ-006 Instr_Ready  output  1  sequencer accepts; transfer when Valid and Ready high on a Clk edge.
REQ-007 Alu_In1, Alu_In2  output  32 each  operands, R[Rn] and R[Rm].
REQ-008 Alu_Opcode, Alu_Cond  output  4 each;  Alu_S  output  1;  Alu_SR_Cont  output  3;  Alu_SR_Bit  output  5;  Alu_Imm  output  16.
REQ-009 Alu_Out  input  32;  Alu_Flags  input  4;  Alu_Cond_Met  input  1  (combinational ALU results).
REQ-010 Done  output  1  one-cycle completion pulse.
REQ-011 Done_Wr  output  1  destination register written this completion.
REQ-012 Done_Rd  output  4  and  Done_Data  output  32  destination index and written value.
REQ-013 Flags_Q  output  4  architectural flags register.
REQ-014 Dbg_Addr  input  4;  Dbg_Data  output  32  combinational read of R[Dbg_Addr].

Function
REQ-015 FSM states IDLE, READ, EXEC, WB:
- IDLE->READ on accept; READ->EXEC; EXEC->WB; WB->IDLE, unconditional.
REQ-016 Instr_Ready is 1 only in IDLE; there is no overlap; throughput is one instruction per 4 cycles.
REQ-017 Instruction is latched on accept; later changes to Instr or Instr_Valid have no effect.
REQ-018 READ: R[Rn], R[Rm] are registered onto Alu_In1/Alu_In2; control fields are registered onto the Alu_* outputs.
- Alu_* outputs hold stable through EXEC and WB.
REQ-019 EXEC: Alu_Out, Alu_Flags, Alu_Cond_Met are sampled into internal result registers at the EXEC->WB edge.
REQ-020 Opcode 1111 (NOP): Alu_Opcode is driven 0000 and Alu_Cond 0000; nothing is written and flags are unchanged; Done still pulses.
REQ-021 Writeback at the WB->IDLE edge, only when sampled Cond_Met=1:
- Opcodes 0000-0111 and 1101 write R[Rd] with the sampled Out.
- Opcode 1011 (CMP) writes only Flags_Q.
- All other opcodes write nothing.
REQ-022 Flags_Q is updated with sampled Flags when Cond_Met=1 and either opcode 0000-0101 with S=1, or opcode 1011.
- Otherwise Flags_Q holds; X flags from the ALU never reach Flags_Q.
REQ-023 Done=1 during WB. Done_Wr reflects REQ-021. Done_Rd = Rd. Done_Data = sampled Out when Done_Wr=1, else 0.
REQ-024 Latency: accept at edge N gives Done high in the cycle after edge N+2; the register is written at edge N+3.
REQ-025 Rn=Rm=Rd is legal; operands are the pre-write value.
REQ-026 Dbg_Data during WB shows the old value; it shows the new value from the next cycle.

Reset
REQ-027 Rst high at a Clk edge: state->IDLE, all 16 registers->0, Flags_Q->0, Done/Done_Wr->0, Done_Rd->0, Done_Data->0, all Alu_* outputs->0.
REQ-028 Reset mid-instruction aborts it with no writeback and no Done; Instr_Ready=1 in the first cycle after Rst falls.

Configuration
REQ-029 Macro ALU_SEQUENCER_EXEC_WAIT_EN: when defined, a state EXEC2 is inserted between EXEC and WB.
- Results are sampled at the EXEC2->WB edge.
- Latency becomes 4 edges; throughput becomes one instruction per 5 cycles.
- When undefined, behaviour is exactly REQ-015..REQ-026.

Verification
REQ-030 Reset, then MOV-imm (Op 0110, Cond 0, Rd=3, Imm=0x1234) -> Done after 3 edges, Done_Wr=1, Done_Data=0x00001234, Dbg R3=0x1234.
REQ-031 R1=5, R2=7; ADD S=1 Rd=4, Rn=1, Rm=2 -> R4=12, Flags_Q = ALU flags value, Instr_Ready low for 3 cycles.
REQ-032 R1=5, R2=7; Cond EQ (0001) ADD Rd=4 -> Cond_Met=0, Done=1, Done_Wr=0, R4 and Flags_Q unchanged.
REQ-033 CMP (1011) R1=7, R2=7 -> Flags_Q updated, no register written, Done_Wr=0.
REQ-034 Assert Rst during EXEC of ADD Rd=5 -> no Done, R5=0, Instr_Ready=1 in the first cycle after Rst falls.
REQ-035 With ALU_SEQUENCER_EXEC_WAIT_EN defined, repeat REQ-030 -> Done after 4 edges, same data.
